e_mdu: RTL and testbench
========================

# e_mdu

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core, executing alongside the ALU. It provides the multi-cycle arithmetic operations: mult, multu, div, divu, mfhi, mflo, mthi and mtlo. It holds the HI/LO register pair and raises Busy for a fixed, configurable latency. The hazard unit stalls on Start|Busy, and the exception/interrupt request Req suppresses any architectural update issued from E.

## Interface
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd family); must be ≥1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- MDUOp  in  4  operation code from the shared package, decoded in D and carried to E.
- Start  in  1  asserted by E when MDUOp is a mult/div class op.
- A, B  in  WIDTH  rs/rt operands after forwarding.
- Req  in  1  exception/interrupt flush from CP0; blocks all writes issued this cycle.
- Busy  out  WIDTH-independent 1  operation in flight.
- HI, LO  out  WIDTH  architectural registers.
- Rd  out  WIDTH  mfhi/mflo read data (HI or LO), else 0; combinational.

## Operation
- FSM states: IDLE, RUN. Down-counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Accept an op when Start && !Busy && !Req && the op is mult/div class.
  - Latch the result pair into pending regs.
  - Load the counter with N (MULT_CYCLES or DIV_CYCLES).
  - Go to RUN.
- RUN:
  - Decrement the counter each cycle.
  - When the counter reaches 1, write the pending pair to HI/LO and go to IDLE.
- mult: {HI,LO} = signed A×B, full 2·WIDTH product. multu: unsigned product.
- div: LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - Signed div of INT_MIN by -1 gives LO=INT_MIN, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero: HI/LO unchanged, but Busy still runs DIV_CYCLES.
- mthi/mtlo: write A to HI/LO at the edge, only when !Busy && !Req. They are never issued while Busy, because the hazard unit stalls them.
- mfhi/mflo: Rd = HI/LO, combinational.
- Start while Busy: ignored, with no state change. The bench flags it as a hazard-unit error.
- Req during RUN does not cancel the in-flight op; its instruction has already passed E.

## Timing
- Reset values: Busy=0, HI=0, LO=0, Rd=0 (given MDUOp none), state IDLE, counter 0.
- Start accepted in cycle t:
  - Busy=1 in cycles t+1 … t+N.
  - HI/LO take the new value at the edge ending t+N and are visible in t+N+1, when Busy=0.
- The hazard unit stalls any MDU op in D while Start|Busy. A back-to-back op can therefore issue no earlier than t+N+1.
- mthi/mtlo: visible the cycle after the write.
- Reset in RUN: aborts at the next edge. Pending result is discarded, HI/LO are cleared, and Busy=0.
- Start and Req in the same cycle: nothing is latched, and Busy stays 0.

## Configuration
- Macro: MDU_MADD_EN.
- Defined: adds madd, maddu, msub and msubu, using MULT_CYCLES latency.
  - The new {HI,LO} = {HI,LO} ± product (signed or unsigned), modulo 2^(2·WIDTH).
  - {HI,LO} is sampled when the op is accepted.
- Undefined: these codes are decoded as MDU_NONE. Start is ignored and there is no HI/LO change.

## Structure
- Shared package holds:
  - MDUOp codes: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU.
  - The FSM state encoding.
- One sub-module, e_mdu_calc: combinational product/quotient/remainder generator, producing the pending HI/LO pair from MDUOp, A, B, HI and LO.

## Test plan
- Reset then idle: Busy=0, HI=LO=0, and mfhi gives Rd=0.
- mult with A=0xFFFFFFFF, B=2 (signed): Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands: HI=1, LO=0xFFFFFFFE.
- div with A=-7, B=2: Busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. div with B=0: HI/LO unchanged after 10 busy cycles.
- Start together with Req for mult 3×4: Busy stays 0 and HI/LO are unchanged. mtlo with Req: LO unchanged.
- reset asserted in the 3rd cycle of a div: next cycle Busy=0 and HI=LO=0. A following mult 3×4 gives LO=12.
- With MDU_MADD_EN defined, HI=0, LO=0xFFFFFFFF, then maddu 1×1: HI=1, LO=0.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// MDU_MADD_EN enables the madd/maddu/msub/msubu accumulate operations.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for several cycles; accumulate ops only exist when enabled.
    function automatic logic is_long_op(input logic [3:0] op);
        logic r;
        case (mdu_op_e'(op))
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational result generator: the HI/LO pair an accepted op will commit.
// Accumulate ops are decoded only under MDU_MADD_EN.
module e_mdu_calc
    import e_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] sprod_s;
    logic [2*WIDTH-1:0] uprod_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   mag_q_s;
    logic [WIDTH-1:0]   mag_r_s;
    logic [WIDTH-1:0]   squo_s;
    logic [WIDTH-1:0]   srem_s;
    logic               b_zero_s;

    assign sprod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign uprod_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed divide on magnitudes: INT_MIN / -1 wraps to INT_MIN with a zero remainder.
    assign mag_a_s  = a[WIDTH-1] ? -a : a;
    assign mag_b_s  = b[WIDTH-1] ? -b : b;
    assign mag_q_s  = mag_a_s / mag_b_s;
    assign mag_r_s  = mag_a_s % mag_b_s;
    assign squo_s   = (a[WIDTH-1] ^ b[WIDTH-1]) ? -mag_q_s : mag_q_s;
    assign srem_s   = a[WIDTH-1] ? -mag_r_s : mag_r_s;
    assign b_zero_s = (b == {WIDTH{1'b0}});

    // Select the pending pair; a zero divisor leaves HI/LO as they are.
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (mdu_op_e'(op))
            MDU_MULT:  {res_hi, res_lo} = sprod_s;
            MDU_MULTU: {res_hi, res_lo} = uprod_s;
            MDU_DIV: begin
                if (!b_zero_s) begin
                    res_hi = srem_s;
                    res_lo = squo_s;
                end else begin
                    res_hi = hi;
                    res_lo = lo;
                end
            end
            MDU_DIVU: begin
                if (!b_zero_s) begin
                    res_hi = a % b;
                    res_lo = a / b;
                end else begin
                    res_hi = hi;
                    res_lo = lo;
                end
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {res_hi, res_lo} = {hi, lo} + sprod_s;
            MDU_MADDU: {res_hi, res_lo} = {hi, lo} + uprod_s;
            MDU_MSUB:  {res_hi, res_lo} = {hi, lo} - sprod_s;
            MDU_MSUBU: {res_hi, res_lo} = {hi, lo} - uprod_s;
`endif
            default: begin
                res_hi = hi;
                res_lo = lo;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers with fixed-latency Busy window.
// MDU_MADD_EN adds the madd/maddu/msub/msubu accumulate ops (MULT_CYCLES latency).
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       MDUOp,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Req,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] Rd
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N  = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N   = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    mdu_state_e       state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] pend_hi_r, pend_hi_s;
    logic [WIDTH-1:0] pend_lo_r, pend_lo_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic [WIDTH-1:0] lo_r, lo_s;
    logic [WIDTH-1:0] calc_hi_s, calc_lo_s;
    logic             accept_s;

    e_mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (MDUOp),
        .a      (A),
        .b      (B),
        .hi     (hi_r),
        .lo     (lo_r),
        .res_hi (calc_hi_s),
        .res_lo (calc_lo_s)
    );

    // A Req in the issue cycle suppresses the op entirely.
    assign accept_s = Start && (state_r == IDLE) && !Req && is_long_op(MDUOp);

    // Next-state, counter, pending-pair and HI/LO update logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pend_hi_s = pend_hi_r;
        pend_lo_s = pend_lo_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s   = RUN;
                    cnt_s     = is_div_op(MDUOp) ? DIV_N : MULT_N;
                    pend_hi_s = calc_hi_s;
                    pend_lo_s = calc_lo_s;
                end else if (!Req && (MDUOp == MDU_MTHI)) begin
                    hi_s = A;
                end else if (!Req && (MDUOp == MDU_MTLO)) begin
                    lo_s = A;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r <= CNT_ONE) begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                    hi_s    = pend_hi_r;
                    lo_s    = pend_lo_r;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State and architectural registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            pend_hi_r <= {WIDTH{1'b0}};
            pend_lo_r <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pend_hi_r <= pend_hi_s;
            pend_lo_r <= pend_lo_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
        end
    end

    assign Busy = (state_r == RUN);
    assign HI   = hi_r;
    assign LO   = lo_r;
    assign Rd   = (MDUOp == MDU_MFHI) ? hi_r :
                  (MDUOp == MDU_MFLO) ? lo_r : {WIDTH{1'b0}};

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus pushes expected HI/LO and busy length,
// a monitor pops and compares whenever the Busy window closes.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   MDUOp;
    logic         Start, Req;
    logic [W-1:0] A, B;
    logic         Busy;
    logic [W-1:0] HI, LO, Rd;

    e_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .Start(Start), .A(A), .B(B),
        .Req(Req), .Busy(Busy), .HI(HI), .LO(LO), .Rd(Rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           n;
        string        name;
    } exp_t;

    exp_t         sb_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    bit           skip_fall = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: measure each Busy window and compare against the queued expectation.
    initial begin
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (Busy === 1'b1) begin
                run++;
            end else if (run > 0) begin
                if (skip_fall) begin
                    skip_fall = 1'b0;
                end else if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_busy: got busy window of %0d cycles, required none", run);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_busy"}, 64'(run), 64'(e.n));
                    chk({e.name, "_hi"}, {32'd0, HI}, {32'd0, e.hi});
                    chk({e.name, "_lo"}, {32'd0, LO}, {32'd0, e.lo});
                end
                run = 0;
            end
        end
    end

    // Reference model: architectural rules in plain 64-bit arithmetic.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int n);
        longint      sa, sb;
        logic [63:0] sp, up, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sp  = 64'(sa * sb);
        up  = {32'd0, a} * {32'd0, b};
        acc = {m_hi, m_lo};
        n   = MC;
        case (op)
            MDU_MULT:  {m_hi, m_lo} = sp;
            MDU_MULTU: {m_hi, m_lo} = up;
            MDU_DIV: begin
                n = DC;
                if (b != 0) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
            end
            MDU_DIVU: begin
                n = DC;
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            MDU_MADD:  {m_hi, m_lo} = acc + sp;
            MDU_MADDU: {m_hi, m_lo} = acc + up;
            MDU_MSUB:  {m_hi, m_lo} = acc - sp;
            MDU_MSUBU: {m_hi, m_lo} = acc - up;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a long op, queue its expectation, wait (bounded) for Busy to drop.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        exp_t e;
        int   n;
        model(op, a, b, n);
        e.hi = m_hi; e.lo = m_lo; e.n = n; e.name = name;
        sb_q.push_back(e);
        MDUOp = op; A = a; B = b; Start = 1'b1;
        tick();
        Start = 1'b0; MDUOp = MDU_NONE;
        for (int i = 0; i < DC + 5 && Busy; i++) tick();
        if (Busy) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got Busy=1 after %0d cycles, required 0", name, DC + 5);
        end
    endtask

    // Start that must be ignored: Busy stays low and HI/LO keep their values.
    task automatic issue_ignored(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic req, input string name);
        MDUOp = op; A = a; B = b; Start = 1'b1; Req = req;
        tick();
        Start = 1'b0; Req = 1'b0; MDUOp = MDU_NONE;
        chk({name, "_busy"}, {63'd0, Busy}, 64'd0);
        tick();
        chk({name, "_hilo"}, {HI, LO}, {m_hi, m_lo});
    endtask

    task automatic mt(input logic [3:0] op, input logic [W-1:0] a, input logic req, input string name);
        MDUOp = op; A = a; Req = req;
        tick();
        MDUOp = MDU_NONE; Req = 1'b0;
        if (!req && op == MDU_MTHI) m_hi = a;
        if (!req && op == MDU_MTLO) m_lo = a;
        chk({name, "_hilo"}, {HI, LO}, {m_hi, m_lo});
    endtask

    task automatic read_chk();
        MDUOp = MDU_MFHI; #1;
        chk("mfhi_rd", {32'd0, Rd}, {32'd0, m_hi});
        MDUOp = MDU_MFLO; #1;
        chk("mflo_rd", {32'd0, Rd}, {32'd0, m_lo});
        MDUOp = MDU_NONE; #1;
        chk("none_rd", {32'd0, Rd}, 64'd0);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        logic [3:0] ops[$];
        reset = 1'b1; MDUOp = MDU_NONE; Start = 1'b0; Req = 1'b0; A = '0; B = '0;
        repeat (2) tick();
        reset = 1'b0;
        chk("reset_busy", {63'd0, Busy}, 64'd0);
        chk("reset_hilo", {HI, LO}, 64'd0);
        read_chk();

        issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2, "mult_neg");
        chk("mult_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
        chk("multu_const", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
        chk("div_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(MDU_DIV, 32'd100, 32'd0, "div_zero");
        chk("div_zero_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        chk("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);
        issue(MDU_DIVU, 32'hFFFF_FFF9, 32'd2, "divu");
        issue_ignored(MDU_MULT, 32'd3, 32'd4, 1'b1, "mult_req");
        mt(MDU_MTLO, 32'h1234_5678, 1'b1, "mtlo_req");
        mt(MDU_MTHI, 32'hCAFE_0001, 1'b0, "mthi");
        read_chk();

        // Reset in the third busy cycle of a divide.
        MDUOp = MDU_DIV; A = 32'd100; B = 32'd3; Start = 1'b1;
        tick();
        Start = 1'b0; MDUOp = MDU_NONE;
        tick();
        tick();
        reset = 1'b1; skip_fall = 1'b1;
        tick();
        reset = 1'b0; m_hi = '0; m_lo = '0;
        chk("rst_run_busy", {63'd0, Busy}, 64'd0);
        chk("rst_run_hilo", {HI, LO}, 64'd0);
        issue(MDU_MULT, 32'd3, 32'd4, "mult_after_rst");
        chk("mult_after_rst_lo", {32'd0, LO}, 64'd12);

`ifdef MDU_MADD_EN
        mt(MDU_MTHI, 32'd0, 1'b0, "madd_prep_hi");
        mt(MDU_MTLO, 32'hFFFF_FFFF, 1'b0, "madd_prep_lo");
        issue(MDU_MADDU, 32'd1, 32'd1, "maddu");
        chk("maddu_const", {HI, LO}, 64'h0000_0001_0000_0000);
        ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO,
                MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
`else
        issue_ignored(MDU_MADDU, 32'd1, 32'd1, 1'b0, "maddu_off");
        ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};
`endif

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, ops.size() - 1)];
            if (op == MDU_MTHI || op == MDU_MTLO) begin
                mt(op, rnd_val(), ($urandom_range(0, 7) == 0), "rnd_mt");
            end else if ($urandom_range(0, 7) == 0) begin
                issue_ignored(op, rnd_val(), rnd_val(), 1'b1, "rnd_req");
            end else begin
                issue(op, rnd_val(), rnd_val(), "rnd_op");
            end
            read_chk();
        end

        repeat (3) tick();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
